// File: rtl/fb_write_bridge.sv
// fb_write_bridge: buffers processor pixel writes and drives the framebuffer
// RAM write port, with a built-in engine that fills the whole frame with one
// colour. Writes are wrapped into the frame as (offset + wr_addr) mod FB_PIXELS.
// Optional macro FB_BOUNDS_CHECK_EN: beats with wr_addr >= FB_PIXELS are
// accepted but discarded, and counted on a saturating drop_count output.
module fb_write_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int FB_PIXELS  = 76800,
  parameter int ADDR_W     = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] offset,
  input  logic              clear_req,
  input  logic [7:0]        clear_color,
  output logic              clear_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data
`ifdef FB_BOUNDS_CHECK_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  localparam logic [ADDR_W:0]   FB_PIX_W = (ADDR_W+1)'(FB_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FB_PIXELS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [1:0]        state;
  logic              alive;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]        fifo_data [FIFO_DEPTH];
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [7:0]        st_data;
  logic [ADDR_W-1:0] clear_cnt;
  logic [7:0]        clear_col;

  logic [ADDR_W:0]   sum_full;
  logic [ADDR_W:0]   phys_full;
  logic              accept;
  logic              push;
  logic              pop;

  // Wrap the offset-relative pixel index into the frame (one subtraction is enough).
  always_comb begin
    sum_full  = {1'b0, offset} + {1'b0, wr_addr};
    phys_full = sum_full;
    if (sum_full >= FB_PIX_W) begin
      phys_full = sum_full - FB_PIX_W;
    end
  end

  assign wr_ready = alive && (state == S_IDLE) && (count != FULL_CNT);
  assign accept   = wr_valid && wr_ready;
  assign pop      = (count != '0) && ((state == S_IDLE) || (state == S_DRAIN));

`ifdef FB_BOUNDS_CHECK_EN
  logic in_range;
  assign in_range = ({1'b0, wr_addr} < FB_PIX_W);
  assign push     = accept && in_range;

  // Count beats discarded for being outside the frame, saturating at all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count <= '0;
    end else if (accept && !in_range && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign push = accept;
`endif

  // FIFO storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ADDR_W'(phys_full);
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  // FIFO bookkeeping plus the pop stage that feeds the RAM write register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive    <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      st_valid <= 1'b0;
      st_addr  <= '0;
      st_data  <= '0;
    end else begin
      alive    <= 1'b1;
      st_valid <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        st_addr <= fifo_addr[rd_ptr];
        st_data <= fifo_data[rd_ptr];
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Control FSM: accept a clear, drain pending beats, then sweep the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      clear_busy <= 1'b0;
      clear_cnt  <= '0;
      clear_col  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear_req) begin
            clear_col  <= clear_color;
            clear_busy <= 1'b1;
            state      <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((count == '0) && !st_valid) begin
            clear_cnt <= '0;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          clear_cnt <= clear_cnt + ADDR_W'(1);
          if (clear_cnt == LAST_PIX) begin
            clear_busy <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

  // Registered RAM write port: clear sweep has priority, otherwise the popped beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (state == S_CLEAR) begin
      mem_we   <= 1'b1;
      mem_addr <= clear_cnt;
      mem_data <= clear_col;
    end else if (st_valid) begin
      mem_we   <= 1'b1;
      mem_addr <= st_addr;
      mem_data <= st_data;
    end else begin
      mem_we <= 1'b0;
    end
  end

endmodule
